// File: rtl/instr_encoder.sv
// MIPS-subset instruction encoder: encodes commands into words, queues them in a small FIFO
// and streams them to instruction memory. Define INSTR_ENC_DELAY_SLOT_EN to append a NOP after control transfers.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_kind,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [15:0] cmd_imm,
    input  logic [25:0] cmd_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        err_illegal,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef INSTR_ENC_DELAY_SLOT_EN
    localparam bit SLOT_EN = 1'b1;
`else
    localparam bit SLOT_EN = 1'b0;
`endif
    // Worst-case entries a single command can consume.
    localparam logic [CW-1:0] NEED = SLOT_EN ? CW'(2) : CW'(1);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd, w_wr1;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_free;
    logic [31:0]   r_addr, w_word;
    logic          r_err, r_run;
    logic          w_legal, w_slot, w_fire, w_push, w_two, w_pop;

    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b1;
        w_slot  = 1'b0;
        case (cmd_kind)
            4'd0:  w_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100001};
            4'd1:  w_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100011};
            4'd2:  w_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b101010};
            4'd3:  begin w_word = {6'b000000, cmd_rs, 15'b0, 6'b001000}; w_slot = 1'b1; end
            4'd4:  w_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
            4'd5:  w_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
            4'd6:  begin w_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm}; w_slot = 1'b1; end
            4'd7:  begin w_word = {6'b000101, cmd_rs, cmd_rt, cmd_imm}; w_slot = 1'b1; end
            4'd8:  w_word = {6'b001100, cmd_rs, cmd_rt, cmd_imm};
            4'd9:  w_word = {6'b001010, cmd_rs, cmd_rt, cmd_imm};
            4'd10: begin w_word = {6'b000010, cmd_target}; w_slot = 1'b1; end
            4'd11: begin w_word = {6'b000011, cmd_target}; w_slot = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

    // Readiness depends only on registered occupancy, so a same-cycle pop never frees space.
    assign w_free    = CW'(DEPTH) - r_cnt;
    assign cmd_ready = r_run && (w_free >= NEED);
    assign w_fire    = cmd_valid && cmd_ready;
    assign w_push    = w_fire && w_legal;
    assign w_two     = w_push && SLOT_EN && w_slot;
    assign w_pop     = (r_state == S_WRITE) && mem_ack;
    assign w_wr1     = r_wr + AW'(1);
    assign w_cnt_nxt = r_cnt + CW'(w_push) + CW'(w_two) - CW'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_cnt != '0) w_state_nxt = S_WRITE;
            S_WRITE: if (mem_ack && (w_cnt_nxt == '0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: it is only observed while the FSM is in WRITE.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_word;
            if (w_two) r_mem[w_wr1] <= 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_addr  <= BASE_ADDR;
            r_err   <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            r_err   <= w_fire && !w_legal;
            r_cnt   <= w_cnt_nxt;
            if (w_push) r_wr <= w_two ? (r_wr + AW'(2)) : w_wr1;
            if (w_pop) begin
                r_rd   <= r_rd + AW'(1);
                r_addr <= r_addr + 32'd4;
            end
        end
    end

    // The head stays queued until acked, which keeps address and data stable while waiting.
    assign mem_req     = (r_state == S_WRITE);
    assign mem_addr    = r_addr;
    assign mem_wdata   = mem_req ? r_mem[r_rd] : 32'h0;
    assign err_illegal = r_err;
    assign busy        = (r_cnt != '0) || mem_req;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic against a queue-based reference.
module tb_instr_encoder;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF8;
    localparam int          DEPTH = 4;
`ifdef INSTR_ENC_DELAY_SLOT_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif

    logic        clk, rst_n, cmd_valid, cmd_ready, mem_req, mem_ack, err_illegal, busy;
    logic [3:0]  cmd_kind;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic [31:0] mem_addr, mem_wdata;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_target(cmd_target), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .err_illegal(err_illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference state: words written-but-not-acked, in order.
    logic [31:0] q[$];
    logic [31:0] m_addr;
    bit          m_req, m_err, m_run;
    logic [31:0] log_a[$], log_d[$];
    int          acc_cnt, err_cnt;

    function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                                        input logic [15:0] imm, input logic [25:0] tgt,
                                        output bit legal, output bit slot);
        logic [31:0] r, i;
        r = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
        i = (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        legal = 1'b1;
        slot  = 1'b0;
        case (k)
            0: return r | 32'h21;
            1: return r | 32'h23;
            2: return r | 32'h2A;
            3: begin slot = 1'b1; return (32'(rs) << 21) | 32'h08; end
            4: return (32'h23 << 26) | i;
            5: return (32'h2B << 26) | i;
            6: begin slot = 1'b1; return (32'h04 << 26) | i; end
            7: begin slot = 1'b1; return (32'h05 << 26) | i; end
            8: return (32'h0C << 26) | i;
            9: return (32'h0A << 26) | i;
            10: begin slot = 1'b1; return (32'h02 << 26) | 32'(tgt); end
            11: begin slot = 1'b1; return (32'h03 << 26) | 32'(tgt); end
            default: begin legal = 1'b0; return 32'h0; end
        endcase
    endfunction

    task automatic step(input bit v, input logic [3:0] k, input logic [4:0] rs, rt, rd,
                        input logic [15:0] imm, input logic [25:0] tgt, input bit ack);
        bit legal, slot, fire, m_ready;
        logic [31:0] w;
        int sz0;
        @(negedge clk);
        cmd_valid = v; cmd_kind = k; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_imm = imm; cmd_target = tgt; mem_ack = ack;
        #1;
        m_ready = m_run && (q.size() <= DEPTH - NEED);
        chk("cmd_ready", cmd_ready, m_ready);
        chk("mem_req", mem_req, m_req);
        chk("busy", busy, q.size() != 0);
        chk("err_illegal", err_illegal, m_err);
        if (m_req) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, q[0]);
        end
        if (err_illegal) err_cnt++;
        if (mem_req && ack) begin log_a.push_back(mem_addr); log_d.push_back(mem_wdata); end
        w = enc(k, rs, rt, rd, imm, tgt, legal, slot);
        fire = v && m_ready;
        if (fire) acc_cnt++;
        @(posedge clk);
        sz0 = q.size();
        if (m_req && ack) begin void'(q.pop_front()); m_addr += 32'd4; end
        if (fire && legal) begin
            q.push_back(w);
            if (NEED == 2 && slot) q.push_back(32'h0);
        end
        m_err = fire && !legal;
        m_req = (sz0 > 0) && (q.size() > 0);
        m_run = 1'b1;
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, ack);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_illegal, 1'b0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        q.delete(); m_addr = BASE; m_req = 0; m_err = 0; m_run = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rdy_before_edge", cmd_ready, 1'b0);
        @(posedge clk);
        m_run = 1'b1;
    endtask

    task automatic clear_logs();
        log_a.delete(); log_d.delete(); acc_cnt = 0; err_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 0; cmd_kind = 0; cmd_rs = 0; cmd_rt = 0; cmd_rd = 0;
        cmd_imm = 0; cmd_target = 0; mem_ack = 0;
        q.delete(); m_addr = BASE; m_req = 0; m_err = 0; m_run = 0;
        clear_logs();
        do_reset();

        // add r3 = r1 + r2, acked as soon as presented
        clear_logs();
        step(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1);
        idle(4, 1);
        chk("add_nwr", log_a.size(), 1);
        if (log_a.size() >= 1) begin
            chk("add_addr", log_a[0], BASE);
            chk("add_data", log_d[0], 32'h0022_1821);
        end
        #1 chk("add_busy_after", busy, 1'b0);

        // lw then jal; second word crosses the address wrap
        clear_logs();
        step(1, 4'd4, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0, 1);
        step(1, 4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0040, 1);
        idle(6, 1);
        chk("lwjal_nwr", log_a.size(), 2 + (NEED - 1));
        if (log_a.size() >= 2) begin
            chk("lw_addr", log_a[0], 32'hFFFF_FFFC);
            chk("lw_data", log_d[0], 32'h8C85_0010);
            chk("jal_addr", log_a[1], 32'h0000_0000);
            chk("jal_data", log_d[1], 32'h0C00_0040);
        end

        // illegal kind: consumed, nothing written, single err pulse
        clear_logs();
        step(1, 4'd13, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0, 1);
        idle(3, 1);
        chk("ill_nwr", log_a.size(), 0);
        chk("ill_pulses", err_cnt, 1);
        step(1, 4'd1, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0, 1);
        idle(4, 1);
        if (log_a.size() >= 1) chk("ill_next_addr", log_a[0], 32'd4 * NEED);
        else chk("ill_next_nwr", log_a.size(), 1);

        // backpressure: ack held low for 10 cycles while 6 commands are offered
        clear_logs();
        for (int i = 0; i < 6; i++) step(1, 4'd0, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0, 26'h0, 0);
        idle(4, 0);
        chk("bp_accepted", acc_cnt, DEPTH - NEED + 1);
        #1 chk("bp_ready_low", cmd_ready, 1'b0);
        chk("bp_nwr", log_a.size(), 0);
        idle(8, 1);

        // reset mid-WRITE with three words queued
        clear_logs();
        for (int i = 0; i < 3; i++) step(1, 4'd2, 5'(i), 5'd3, 5'd4, 16'h0, 26'h0, 0);
        idle(2, 0);
        do_reset();
        idle(3, 1);
        chk("rst_nwr", log_a.size(), 0);
        step(1, 4'd8, 5'd1, 5'd1, 5'd0, 16'h7FFF, 26'h0, 1);
        idle(4, 1);
        if (log_a.size() >= 1) chk("rst_next_addr", log_a[0], BASE);
        else chk("rst_next_nwr", log_a.size(), 1);

`ifdef INSTR_ENC_DELAY_SLOT_EN
        do_reset();
        clear_logs();
        step(1, 4'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1);
        idle(6, 1);
        chk("ds_nwr", log_a.size(), 2);
        if (log_a.size() >= 2) begin
            chk("ds_beq_addr", log_a[0], BASE);
            chk("ds_beq_data", log_d[0], 32'h1022_FFFF);
            chk("ds_nop_addr", log_a[1], BASE + 32'd4);
            chk("ds_nop_data", log_d[1], 32'h0);
        end
`endif

        // random traffic with one asynchronous reset in the middle
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 5'($urandom),
                 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
                 $urandom_range(0, 9) < 7);
        end
        idle(12, 1);
        #1 chk("final_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
